// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: writes a seed+beat pattern or reads it back and checks it.
// All AXI and status outputs come from registers; no AXI input reaches an output combinationally.
module axi_burst_master #(
   parameter int DW    = 32,
   parameter int AW    = 8,
   parameter int ID_WD = 2
) (
   input  logic             M_AXI_ACLK,
   input  logic             M_AXI_ARSTN,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [AW-1:0]    cmd_addr,
   input  logic [7:0]       cmd_len,
   input  logic [DW-1:0]    cmd_seed,
   output logic             done,
   output logic             done_err,
   output logic [15:0]      err_cnt,
   output logic             M_AXI_AWVALID,
   input  logic             M_AXI_AWREADY,
   output logic [ID_WD-1:0] M_AXI_AWID,
   output logic [AW-1:0]    M_AXI_AWADDR,
   output logic [7:0]       M_AXI_AWLEN,
   output logic [2:0]       M_AXI_AWSIZE,
   output logic [1:0]       M_AXI_AWBURST,
   output logic             M_AXI_WVALID,
   input  logic             M_AXI_WREADY,
   output logic [DW-1:0]    M_AXI_WDATA,
   output logic [DW/8-1:0]  M_AXI_WSTRB,
   output logic             M_AXI_WLAST,
   input  logic             M_AXI_BVALID,
   output logic             M_AXI_BREADY,
   input  logic [ID_WD-1:0] M_AXI_BID,
   input  logic [1:0]       M_AXI_BRESP,
   output logic             M_AXI_ARVALID,
   input  logic             M_AXI_ARREADY,
   output logic [ID_WD-1:0] M_AXI_ARID,
   output logic [AW-1:0]    M_AXI_ARADDR,
   output logic [7:0]       M_AXI_ARLEN,
   output logic [2:0]       M_AXI_ARSIZE,
   output logic [1:0]       M_AXI_ARBURST,
   input  logic             M_AXI_RVALID,
   output logic             M_AXI_RREADY,
   input  logic [ID_WD-1:0] M_AXI_RID,
   input  logic [DW-1:0]    M_AXI_RDATA,
   input  logic [1:0]       M_AXI_RRESP,
   input  logic             M_AXI_RLAST
);

   localparam logic [2:0]    SIZE       = 3'($clog2(DW/8));
   localparam logic [AW-1:0] ALIGN_MASK = ~AW'(DW/8 - 1);

   typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA} state_t;

   state_t           r_state;
   logic [AW-1:0]    r_addr;
   logic [7:0]       r_len;
   logic [DW-1:0]    r_seed;
   logic [7:0]       r_beat;
   logic             r_err;
   logic [ID_WD-1:0] r_wid;
   logic [ID_WD-1:0] r_rid;
   logic [15:0]      r_err_cnt;
   logic             r_done;
   logic             r_done_err;
   logic             r_cmd_ready;
   logic             r_awvalid;
   logic             r_wvalid;
   logic [DW-1:0]    r_wdata;
   logic             r_wlast;
   logic             r_bready;
   logic             r_arvalid;
   logic             r_rready;

   logic [DW-1:0]    w_exp;
   logic             w_last_beat;
   logic             w_r_bad;
   logic             w_b_bad;
   logic [15:0]      w_err_cnt_inc;

   assign w_exp         = r_seed + DW'(r_beat);
   assign w_last_beat   = (r_beat == r_len);
   assign w_r_bad       = (M_AXI_RDATA != w_exp) || (M_AXI_RRESP != 2'b00) ||
                          (M_AXI_RID != r_rid) || (M_AXI_RLAST != w_last_beat);
   assign w_b_bad       = (M_AXI_BRESP != 2'b00) || (M_AXI_BID != r_wid);
   assign w_err_cnt_inc = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARSTN) begin
      if (!M_AXI_ARSTN) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_len       <= '0;
         r_seed      <= '0;
         r_beat      <= '0;
         r_err       <= 1'b0;
         r_wid       <= '0;
         r_rid       <= '0;
         r_err_cnt   <= '0;
         r_done      <= 1'b0;
         r_done_err  <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_wdata     <= '0;
         r_wlast     <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_done_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_addr      <= cmd_addr & ALIGN_MASK;
                  r_len       <= cmd_len;
                  r_seed      <= cmd_seed;
                  r_beat      <= '0;
                  r_err       <= 1'b0;
                  r_cmd_ready <= 1'b0;
                  if (cmd_write) begin
                     r_awvalid <= 1'b1;
                     r_state   <= S_WADDR;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= S_RADDR;
                  end
               end
            end
            S_WADDR: begin
               if (M_AXI_AWREADY) begin
                  r_awvalid <= 1'b0;
                  r_wvalid  <= 1'b1;
                  r_wdata   <= r_seed;
                  r_wlast   <= (r_len == 8'd0);
                  r_state   <= S_WDATA;
               end
            end
            S_WDATA: begin
               if (M_AXI_WREADY) begin
                  // Pre-compute the next beat's payload so WDATA/WLAST stay registered.
                  r_beat  <= r_beat + 8'd1;
                  r_wdata <= w_exp + DW'(1);
                  r_wlast <= ((r_beat + 8'd1) == r_len);
                  if (r_wlast) begin
                     r_wvalid <= 1'b0;
                     r_wlast  <= 1'b0;
                     r_bready <= 1'b1;
                     r_state  <= S_WRESP;
                  end
               end
            end
            S_WRESP: begin
               if (M_AXI_BVALID) begin
                  if (w_b_bad) r_err_cnt <= w_err_cnt_inc;
                  r_bready    <= 1'b0;
                  r_done      <= 1'b1;
                  r_done_err  <= r_err | w_b_bad;
                  r_wid       <= r_wid + 1'b1;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            S_RADDR: begin
               if (M_AXI_ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (M_AXI_RVALID) begin
                  if (w_r_bad) begin
                     r_err_cnt <= w_err_cnt_inc;
                     r_err     <= 1'b1;
                  end
                  if (r_beat != 8'hFF) r_beat <= r_beat + 8'd1;
                  // A short or long slave burst is tolerated; only RLAST closes it.
                  if (M_AXI_RLAST) begin
                     r_rready    <= 1'b0;
                     r_done      <= 1'b1;
                     r_done_err  <= r_err | w_r_bad;
                     r_rid       <= r_rid + 1'b1;
                     r_cmd_ready <= 1'b1;
                     r_state     <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign done          = r_done;
   assign done_err      = r_done_err;
   assign err_cnt       = r_err_cnt;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_AWID    = r_wid;
   assign M_AXI_AWADDR  = r_addr;
   assign M_AXI_AWLEN   = r_len;
   assign M_AXI_AWSIZE  = SIZE;
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_WVALID  = r_wvalid;
   assign M_AXI_WDATA   = r_wdata;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WLAST   = r_wlast;
   assign M_AXI_BREADY  = r_bready;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_ARID    = r_rid;
   assign M_AXI_ARADDR  = r_addr;
   assign M_AXI_ARLEN   = r_len;
   assign M_AXI_ARSIZE  = SIZE;
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a reactive 256-byte AXI slave model driven on the falling edge.
module tb_axi_burst_master;

   logic        aclk = 1'b0;
   logic        arstn = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [7:0]  cmd_addr = '0, cmd_len = '0;
   logic [31:0] cmd_seed = '0;
   logic        done, done_err;
   logic [15:0] err_cnt;
   logic        awvalid, awready = 1'b0;
   logic [1:0]  awid, arid;
   logic [7:0]  awaddr, awlen, araddr, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst;
   logic        wvalid, wready = 1'b0, wlast;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid = 1'b0, bready;
   logic [1:0]  bid = '0, bresp = '0;
   logic        arvalid, arready = 1'b0;
   logic        rvalid = 1'b0, rready, rlast = 1'b0;
   logic [1:0]  rid = '0, rresp = '0;
   logic [31:0] rdata = '0;

   int vectors = 0, miscompares = 0;
   int cyc = 0;

   axi_burst_master #(.DW(32), .AW(8), .ID_WD(2)) dut (
      .M_AXI_ACLK(aclk), .M_AXI_ARSTN(arstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
      .done(done), .done_err(done_err), .err_cnt(err_cnt),
      .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWID(awid),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata),
      .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
      .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BID(bid), .M_AXI_BRESP(bresp),
      .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARID(arid),
      .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RID(rid),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc++;

   // Slave model state and observation records.
   logic [31:0] mem [64];
   bit          stall_en = 1'b0;
   logic [1:0]  inject_bresp = 2'b00;
   bit          s_aw_pend, s_b_pend, s_ar_pend, s_r_took;
   logic [7:0]  s_waddr, s_raddr, s_rlen, s_rbeat;
   logic [1:0]  s_bid, s_rid;
   logic [7:0]  aw_addr_q, aw_len_q;
   logic [1:0]  aw_id_q, ar_id_q;
   int          aw_cyc, b_cyc, r_beats, done_cnt, stab_viol, stall_cnt;
   logic [31:0] w_data_q[$];
   bit          w_last_q[$];
   int          w_cyc_q[$];
   bit          p_aw, p_w, p_ar;
   logic [7:0]  p_awaddr, p_awlen, p_araddr, p_arlen;
   logic [1:0]  p_awid, p_arid;
   logic [31:0] p_wdata;
   logic        p_wlast;

   function automatic bit pick();
      return stall_en ? bit'($urandom_range(0, 1)) : 1'b1;
   endfunction

   always @(negedge aclk) begin
      if (done) done_cnt++;
      if (!arstn) begin
         s_aw_pend = 0; s_b_pend = 0; s_ar_pend = 0; s_r_took = 0;
         p_aw = 0; p_w = 0; p_ar = 0;
         awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      end else begin
         // Anything stalled at the last edge must still be presented unchanged.
         if (p_aw && (!awvalid || awaddr !== p_awaddr || awlen !== p_awlen || awid !== p_awid)) stab_viol++;
         if (p_w && (!wvalid || wdata !== p_wdata || wlast !== p_wlast)) stab_viol++;
         if (p_ar && (!arvalid || araddr !== p_araddr || arlen !== p_arlen || arid !== p_arid)) stab_viol++;
         awready = !s_aw_pend && !s_b_pend && pick();
         wready  = s_aw_pend && pick();
         arready = !s_ar_pend && pick();
         if (!s_b_pend) bvalid = 0;
         else if (!bvalid) bvalid = pick();
         bid = s_bid; bresp = inject_bresp;
         if (!s_ar_pend) rvalid = 0;
         else if (!rvalid || s_r_took) rvalid = pick();
         s_r_took = 0;
         rdata = mem[s_raddr[7:2]]; rid = s_rid; rresp = 2'b00; rlast = (s_rbeat == s_rlen);
         p_aw = awvalid && !awready; p_awaddr = awaddr; p_awlen = awlen; p_awid = awid;
         p_w  = wvalid && !wready;   p_wdata = wdata;   p_wlast = wlast;
         p_ar = arvalid && !arready; p_araddr = araddr; p_arlen = arlen; p_arid = arid;
         if (p_aw || p_w || p_ar) stall_cnt++;
         if (awvalid && awready) begin
            s_aw_pend = 1; s_waddr = awaddr; s_bid = awid;
            aw_addr_q = awaddr; aw_len_q = awlen; aw_id_q = awid; aw_cyc = cyc;
         end
         if (wvalid && wready) begin
            mem[s_waddr[7:2]] = wdata; s_waddr = s_waddr + 8'd4;
            w_data_q.push_back(wdata); w_last_q.push_back(wlast); w_cyc_q.push_back(cyc);
            if (wlast) begin s_aw_pend = 0; s_b_pend = 1; end
         end
         if (bvalid && bready) begin s_b_pend = 0; b_cyc = cyc; end
         if (arvalid && arready) begin
            s_ar_pend = 1; s_raddr = araddr; s_rlen = arlen; s_rbeat = 0; s_rid = arid; ar_id_q = arid;
         end
         if (rvalid && rready) begin
            r_beats++; s_r_took = 1; b_cyc = cyc;
            if (s_rbeat == s_rlen) s_ar_pend = 0;
            s_raddr = s_raddr + 8'd4; s_rbeat = s_rbeat + 8'd1;
         end
      end
   end

   task automatic send_cmd(input bit w, input logic [7:0] a, input logic [7:0] l, input logic [31:0] s);
      int n = 0;
      cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_seed = s;
      while (!cmd_ready && n < 200) begin @(negedge aclk); n++; end
      if (!cmd_ready) begin
         vectors++; miscompares++;
         $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, want 1", cmd_ready, n);
      end
      @(negedge aclk);
      cmd_valid = 0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 3000) begin @(negedge aclk); n++; end
      if (!done) begin
         vectors++; miscompares++;
         $display("FAIL done_timeout: done=%b after %0d cycles, want 1", done, n);
      end
   endtask

   task automatic test_reset();
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
      vectors++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
         miscompares++; $display("FAIL rst_valid_ready: got %b want 00000", {awvalid, wvalid, bready, arvalid, rready}); end
      vectors++; if ({done, done_err, wlast} !== 3'b0) begin
         miscompares++; $display("FAIL rst_done_wlast: got %b want 000", {done, done_err, wlast}); end
      vectors++; if (err_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
      vectors++; if ({awid, arid} !== 4'b0) begin miscompares++; $display("FAIL rst_ids: got %b want 0000", {awid, arid}); end
      vectors++; if ({awsize, awburst, arsize, arburst, wstrb} !== {3'd2, 2'b01, 3'd2, 2'b01, 4'hF}) begin
         miscompares++; $display("FAIL const_fields: got %h", {awsize, awburst, arsize, arburst, wstrb}); end
      arstn = 1;
      @(negedge aclk);
   endtask

   task automatic test_write_full();
      int bad = 0;
      stall_en = 0;
      w_data_q.delete(); w_last_q.delete(); w_cyc_q.delete();
      send_cmd(1, 8'h00, 8'd63, 32'd0);
      vectors++; if (awvalid !== 1'b1) begin miscompares++; $display("FAIL wr_awvalid_n1: got %b want 1", awvalid); end
      wait_done();
      vectors++; if (done_err !== 1'b0) begin miscompares++; $display("FAIL wr_done_err: got %b want 0", done_err); end
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL wr_ready_at_done: got %b want 1", cmd_ready); end
      vectors++; if (cyc !== b_cyc + 1) begin miscompares++; $display("FAIL wr_done_timing: got cyc %0d want %0d", cyc, b_cyc + 1); end
      @(negedge aclk);
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL wr_done_width: got %b want 0", done); end
      vectors++; if ({aw_addr_q, aw_len_q, aw_id_q} !== {8'h00, 8'd63, 2'd0}) begin
         miscompares++; $display("FAIL wr_aw_fields: got %h want %h", {aw_addr_q, aw_len_q, aw_id_q}, {8'h00, 8'd63, 2'd0}); end
      vectors++; if (w_data_q.size() !== 64) begin miscompares++; $display("FAIL wr_beats: got %0d want 64", w_data_q.size()); end
      for (int k = 0; k < w_data_q.size(); k++) begin
         if (w_data_q[k] !== 32'(k) || w_last_q[k] !== (k == 63) || w_cyc_q[k] !== aw_cyc + 1 + k) bad++;
      end
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL wr_beat_stream: got %0d bad beats want 0", bad); end
   endtask

   task automatic test_read_full();
      r_beats = 0;
      send_cmd(0, 8'h00, 8'd63, 32'd0);
      vectors++; if (arvalid !== 1'b1) begin miscompares++; $display("FAIL rd_arvalid_n1: got %b want 1", arvalid); end
      wait_done();
      vectors++; if (done_err !== 1'b0) begin miscompares++; $display("FAIL rd_done_err: got %b want 0", done_err); end
      @(negedge aclk);
      vectors++; if (r_beats !== 64) begin miscompares++; $display("FAIL rd_beats: got %0d want 64", r_beats); end
      vectors++; if (ar_id_q !== 2'd0) begin miscompares++; $display("FAIL rd_arid: got %0d want 0", ar_id_q); end
      vectors++; if (err_cnt !== 16'd0) begin miscompares++; $display("FAIL rd_err_cnt: got %0d want 0", err_cnt); end
   endtask

   task automatic test_back_to_back();
      int bad_err = 0, bad_id = 0, bad_dat = 0;
      logic [7:0]  a, l;
      logic [31:0] s;
      stall_en = 1; stab_viol = 0; stall_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         a = 8'($urandom_range(0, 255)); l = 8'($urandom_range(0, 15)); s = $urandom;
         w_data_q.delete(); w_last_q.delete(); w_cyc_q.delete();
         send_cmd(1, a, l, s);
         wait_done();
         if (done_err !== 1'b0) bad_err++;
         @(negedge aclk);
         if (aw_id_q !== 2'(i + 1) || aw_addr_q !== (a & 8'hFC)) bad_id++;
         if (w_data_q.size() !== int'(l) + 1) bad_dat++;
         for (int k = 0; k < w_data_q.size(); k++)
            if (w_data_q[k] !== s + 32'(k) || w_last_q[k] !== (k == int'(l))) bad_dat++;
         send_cmd(0, a, l, s);
         wait_done();
         if (done_err !== 1'b0) bad_err++;
         @(negedge aclk);
         if (ar_id_q !== 2'(i + 1)) bad_id++;
      end
      stall_en = 0;
      vectors++; if (bad_err !== 0) begin miscompares++; $display("FAIL b2b_done_err: got %0d bursts flagged want 0", bad_err); end
      vectors++; if (bad_id !== 0) begin miscompares++; $display("FAIL b2b_id_addr: got %0d bad want 0", bad_id); end
      vectors++; if (bad_dat !== 0) begin miscompares++; $display("FAIL b2b_wdata: got %0d bad want 0", bad_dat); end
      vectors++; if (stab_viol !== 0 || stall_cnt == 0) begin
         miscompares++; $display("FAIL b2b_stable: got %0d violations over %0d stalls want 0 over >0", stab_viol, stall_cnt); end
      vectors++; if (err_cnt !== 16'd0) begin miscompares++; $display("FAIL b2b_err_cnt: got %0d want 0", err_cnt); end
   endtask

   task automatic test_mismatch();
      send_cmd(1, 8'h00, 8'd3, 32'd0);
      wait_done();
      @(negedge aclk);
      send_cmd(0, 8'h00, 8'd3, 32'd5);
      wait_done();
      vectors++; if (done_err !== 1'b1) begin miscompares++; $display("FAIL mis_done_err: got %b want 1", done_err); end
      @(negedge aclk);
      vectors++; if (err_cnt !== 16'd4) begin miscompares++; $display("FAIL mis_err_cnt: got %0d want 4", err_cnt); end
   endtask

   task automatic test_bresp_err();
      inject_bresp = 2'b10;
      send_cmd(1, 8'h07, 8'd0, 32'd9);
      vectors++; if (awaddr !== 8'h04) begin miscompares++; $display("FAIL align_awaddr: got %h want 04", awaddr); end
      wait_done();
      vectors++; if (done_err !== 1'b1) begin miscompares++; $display("FAIL bresp_done_err: got %b want 1", done_err); end
      @(negedge aclk);
      inject_bresp = 2'b00;
      vectors++; if (err_cnt !== 16'd5) begin miscompares++; $display("FAIL bresp_err_cnt: got %0d want 5", err_cnt); end
   endtask

   task automatic test_reset_mid();
      int n = 0, dc;
      dc = done_cnt;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h40; cmd_len = 8'd7; cmd_seed = 32'd100;
      @(negedge aclk);
      cmd_valid = 0;
      while (!(wvalid && wdata == 32'd102) && n < 50) begin @(negedge aclk); n++; end
      vectors++; if (wdata !== 32'd102) begin miscompares++; $display("FAIL mid_reach_beat2: got %0d want 102", wdata); end
      arstn = 0;
      #1;
      vectors++; if ({wvalid, awvalid, bready} !== 3'b000) begin
         miscompares++; $display("FAIL mid_async_drop: got %b want 000", {wvalid, awvalid, bready}); end
      repeat (3) @(negedge aclk);
      arstn = 1;
      @(negedge aclk);
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_cmd_ready: got %b want 1", cmd_ready); end
      vectors++; if (err_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); end
      vectors++; if (done_cnt !== dc) begin miscompares++; $display("FAIL mid_no_done: got %0d pulses want %0d", done_cnt, dc); end
      send_cmd(1, 8'h10, 8'd0, 32'd1);
      vectors++; if (awid !== 2'd0) begin miscompares++; $display("FAIL mid_wid_reset: got %0d want 0", awid); end
      wait_done();
      vectors++; if (done_err !== 1'b0) begin miscompares++; $display("FAIL mid_post_done_err: got %b want 0", done_err); end
      @(negedge aclk);
   endtask

   initial begin
      repeat (3) @(negedge aclk);
      test_reset();
      test_write_full();
      test_read_full();
      test_back_to_back();
      test_mismatch();
      test_bresp_err();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Single-outstanding AXI4 burst master that sequences the memory-mapped `axi_slave` RAM from a simple command port. Each command runs one INCR write or read burst. Write data is a generated pattern (`seed + beat`). Read data is checked against the same pattern, and the block reports per-burst status plus a running error count; it sits between test/config logic and the slave's AXI port.

## Interface
- DW, 32, data width in bits (multiple of 8)
- AW, 8, byte address width
- ID_WD, 2, AXI ID width
- M_AXI_ACLK  in  1  clock, all logic on rising edge
- M_AXI_ARSTN  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read-and-check burst
- cmd_addr  in  AW  start byte address; low $clog2(DW/8) bits ignored (forced 0)
- cmd_len  in  8  AXI LEN (beats − 1)
- cmd_seed  in  DW  pattern base; beat k data = cmd_seed + k (mod 2^DW)
- done  out  1  one-cycle pulse at burst completion
- done_err  out  1  valid with done; 1 = bad RESP/ID/LAST or data mismatch in that burst
- err_cnt  out  16  saturating count of erroneous beats/responses since reset
- M_AXI_AWVALID / AWREADY / AWID / AWADDR / AWLEN  out / in / out / out / out  1 / 1 / ID_WD / AW / 8  write address channel
- M_AXI_AWSIZE, M_AXI_ARSIZE  out  3  constant $clog2(DW/8)
- M_AXI_AWBURST, M_AXI_ARBURST  out  2  constant 2'b01 (INCR)
- M_AXI_WVALID / WREADY / WDATA / WSTRB / WLAST  out / in / out / out / out  1 / 1 / DW / DW/8 / 1  write data; WSTRB all ones
- M_AXI_BVALID / BREADY / BID / BRESP  in / out / in / in  1 / 1 / ID_WD / 2  write response
- M_AXI_ARVALID / ARREADY / ARID / ARADDR / ARLEN  out / in / out / out / out  1 / 1 / ID_WD / AW / 8  read address channel
- M_AXI_RVALID / RREADY / RID / RDATA / RRESP / RLAST  in / out / in / in / in / in  1 / 1 / ID_WD / DW / 2 / 1  read data

## Operation
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
- IDLE: cmd_ready = 1. A handshake latches addr (aligned), len and seed, and clears beat counter `beat` (8 bit) and burst error flag. Next state is WADDR if cmd_write, else RADDR.
- WADDR: AWVALID = 1 with AWID = wid, AWADDR, AWLEN stable until AWREADY; then go to WDATA. No W beat is issued before the AW handshake.
- WDATA: WVALID = 1, WDATA = seed + beat, WLAST = (beat == len).
  - Each W handshake increments beat.
  - The handshake with WLAST goes to WRESP.
- WRESP: BREADY = 1. On BVALID, flag an error if BRESP != 0 or BID != wid (+1 err_cnt). Then go to IDLE, pulse done, and set wid <= wid + 1 (wraps).
- RADDR: ARVALID = 1 with ARID = rid until ARREADY; then go to RDATA.
- RDATA: RREADY = 1. Each R handshake is one beat.
  - The beat is erroneous if RDATA != seed + beat, RRESP != 0, RID != rid, or RLAST != (beat == len).
  - Each erroneous beat adds 1 to err_cnt and sets the burst flag.
  - beat saturates at 255.
  - The burst ends only on the RLAST handshake: go to IDLE, pulse done, rid <= rid + 1.
- err_cnt saturates at 16'hFFFF and clears only on reset.
- Addresses wrap modulo 2^AW inside the slave; the block does not check range.

## Timing
- Reset: all VALID and READY outputs are 0, except cmd_ready = 1 (IDLE). done, done_err, err_cnt, wid, rid are 0. WLAST = 0.
- Reset asserted mid-burst drops every VALID/READY asynchronously and abandons the burst without a done pulse.
- All outputs are registered or decoded from state plus registers; there are no combinational paths from AXI inputs to outputs.
- cmd accepted at edge N: AWVALID/ARVALID high in cycle N+1.
- First W beat is the cycle after the AW handshake. With WREADY held at 1, beats run back-to-back, len+1 cycles.
- done and done_err are asserted for exactly one cycle: the cycle after the final B or RLAST handshake. cmd_ready is 1 in that same cycle, so a new command can be accepted then.
- VALID outputs never drop before their handshake completes, and their payloads stay stable while stalled.
- At most one burst is outstanding; the read and write paths never run concurrently.

## Test plan
- Write addr 0x00, len 63, seed 0, slave always ready -> AWLEN 63, WDATA 0..63 on consecutive beats, WLAST on beat 63, done with done_err 0, AWID 0.
- Read addr 0x00, len 63, seed 0 after that write -> 64 R beats, done_err 0, err_cnt stays 0, ARID 0.
- Random AWREADY/WREADY/BREADY-side and RVALID stalls (random VALID/READY toggling) over 20 write/read pairs, len 0..15, random seeds -> payloads stable while stalled, every done_err 0, wid/rid wrap after 4 bursts.
- Read with seed 5 over data written with seed 0, len 3 -> 4 mismatches, err_cnt = 4, done_err 1.
- Slave returns BRESP = 2'b10 -> done_err 1, err_cnt + 1; cmd_addr 0x07 is issued as AWADDR 0x04.
- Assert reset during WDATA beat 2 -> WVALID 0 immediately, no done pulse, cmd_ready 1 after release, err_cnt 0.
